dmem_responder: RTL and testbench

Shared data-memory responder serving the D-ports of NCORES pipeline cores. It arbitrates round-robin among pending load/store requests and performs byte-enabled word writes or word reads on a single-port on-chip array. It returns read data plus a one-cycle `ready` pulse to the served core. It sits between the cores' MEM stages and the backing SRAM, with one D-port per core and stall driven by `ready`.

---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Shared data-memory responder: round-robin arbitration of per-core load/store
// requests onto a single-port word array, with a one-cycle ready pulse per completion.
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NCORES      = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        core_memRead,
  input  logic [NCORES-1:0]        core_memWrite,
  input  logic [NCORES*4-1:0]      core_be,
  input  logic [NCORES*XLEN-1:0]   core_addr,
  input  logic [NCORES*XLEN-1:0]   core_wdata,
  output logic [NCORES*XLEN-1:0]   core_rdata,
  output logic [NCORES-1:0]        core_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     rr_q;
  logic              wr_q;
  logic [3:0]        be_q;
  logic [AW-1:0]     widx_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [NCORES-1:0] ready_q;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  logic [NCORES-1:0] pending;
  logic              win_valid;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     rr_next;
  logic              win_wr;
  logic [3:0]        win_be;
  logic [AW-1:0]     win_widx;
  logic [XLEN-1:0]   win_wdata;
  logic [NCORES-1:0] grant_onehot;
  int unsigned       cand;
  int unsigned       base;

  // First pending core at or after the RR pointer; the core in RESP is excluded.
  always_comb begin
    pending = core_memRead | core_memWrite;
    if (state_q == StResp) pending[grant_q] = 1'b0;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      cand = (32'(rr_q) + k) % NCORES;
      if (!win_valid && pending[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
    cand      = (32'(win_idx) + 1) % NCORES;
    rr_next   = cand[IW-1:0];
    base      = 32'(win_idx) * XLEN;
    win_wr    = core_memWrite[win_idx];
    win_be    = core_be[4*32'(win_idx) +: 4];
    win_widx  = core_addr[base + 2 +: AW];
    win_wdata = core_wdata[base +: XLEN];
    grant_onehot          = '0;
    grant_onehot[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          ready_q <= '0;
          if (win_valid) begin
            grant_q <= win_idx;
            rr_q    <= rr_next;
            wr_q    <= win_wr;
            be_q    <= win_be;
            widx_q  <= win_widx;
            wdata_q <= win_wdata;
            state_q <= StAccess;
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          rdata_q <= wr_q ? '0 : mem[widx_q];
          ready_q <= grant_onehot;
          state_q <= StResp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is not reset; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StAccess && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[widx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    core_rdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (ready_q[i]) core_rdata[i*XLEN +: XLEN] = rdata_q;
    end
  end

  assign core_ready = ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NC    = 4;
  localparam int unsigned DEPTH = 1024;

  logic               clk = 1'b0;
  logic               rst;
  logic [NC-1:0]      core_memRead;
  logic [NC-1:0]      core_memWrite;
  logic [NC*4-1:0]    core_be;
  logic [NC*XLEN-1:0] core_addr;
  logic [NC*XLEN-1:0] core_wdata;
  logic [NC*XLEN-1:0] core_rdata;
  logic [NC-1:0]      core_ready;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.XLEN(XLEN), .NCORES(NC), .DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_memRead (core_memRead),
    .core_memWrite(core_memWrite),
    .core_be      (core_be),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_ready   (core_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
    core_memRead[c]          = rd;
    core_memWrite[c]         = wr;
    core_be[4*c +: 4]        = be;
    core_addr[c*XLEN +: 32]  = addr;
    core_wdata[c*XLEN +: 32] = wd;
  endtask

  task automatic drop(input int c);
    core_memRead[c]  = 1'b0;
    core_memWrite[c] = 1'b0;
  endtask

  // Issue one request from an idle FSM, wait for its ready, then let the FSM return to idle.
  task automatic serve(input int c, input bit rd, input bit wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output int lat);
    logic [NC-1:0] others;
    set_req(c, rd, wr, be, addr, wd);
    lat   = -1;
    rdata = 'x;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (core_ready[c]) begin
        lat    = n;
        rdata  = core_rdata[c*XLEN +: 32];
        others = core_ready;
        others[c] = 1'b0;
        check_eq("serve_others_ready", 32'(others), 32'h0);
        break;
      end
    end
    drop(c);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          lat;
  logic [31:0] pre [NC];
  int          got_cyc [NC];
  logic [31:0] got_dat [NC];
  int          order [8];
  int          ocyc [8];
  int          n;

  initial begin
    rst = 1'b1;
    core_memRead = '0; core_memWrite = '0; core_be = '0; core_addr = '0; core_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", 32'(core_ready), 32'h0);
    check_eq("reset_rdata", core_rdata[31:0] | core_rdata[63:32] | core_rdata[95:64]
             | core_rdata[127:96], 32'h0);
    rst = 1'b0;

    // Single write then read
    serve(0, 0, 1, 4'hF, 32'h40, 32'hDEADBEEF, rd, lat);
    check_eq("wr40_latency", 32'(lat), 32'd2);
    serve(0, 1, 0, 4'hF, 32'h40, 32'h0, rd, lat);
    check_eq("rd40_latency", 32'(lat), 32'd2);
    check_eq("rd40_data", rd, 32'hDEADBEEF);

    // Byte enables
    serve(0, 0, 1, 4'hF, 32'h80, 32'h11223344, rd, lat);
    serve(0, 0, 1, 4'b0101, 32'h80, 32'hAABBCCDD, rd, lat);
    serve(0, 1, 0, 4'h0, 32'h80, 32'h0, rd, lat);
    check_eq("be0101_data", rd, 32'h11BB33DD);
    serve(0, 0, 1, 4'h0, 32'h80, 32'hFFFFFFFF, rd, lat);
    check_eq("be0000_latency", 32'(lat), 32'd2);
    serve(0, 1, 0, 4'hF, 32'h80, 32'h0, rd, lat);
    check_eq("be0000_data", rd, 32'h11BB33DD);

    // Read+write together is a write and returns zero
    serve(1, 1, 1, 4'hF, 32'h200, 32'h12345678, rd, lat);
    check_eq("rdwr_rdata_zero", rd, 32'h0);
    serve(1, 1, 0, 4'hF, 32'h200, 32'h0, rd, lat);
    check_eq("rdwr_committed", rd, 32'h12345678);

    // Full contention from reset
    for (int c = 0; c < NC; c++) begin
      pre[c] = 32'hA0A00000 + 32'(c * 17 + 1);
      serve(0, 0, 1, 4'hF, 32'h100 + 32'(4 * c), pre[c], rd, lat);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      set_req(c, 1, 0, 4'hF, 32'h100 + 32'(4 * c), 32'h0);
      got_cyc[c] = -1;
      got_dat[c] = 'x;
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      check_eq("ct_onehot", 32'($countones(core_ready) <= 1), 32'd1);
      for (int c = 0; c < NC; c++) begin
        if (core_ready[c]) begin
          got_cyc[c] = cyc;
          got_dat[c] = core_rdata[c*XLEN +: 32];
          drop(c);
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      check_eq($sformatf("ct_cycle_core%0d", c), 32'(got_cyc[c]), 32'(2 * c + 2));
      check_eq($sformatf("ct_data_core%0d", c), got_dat[c], pre[c]);
    end

    // Fairness: core1 continuous, core2 once; pointer is back at 0
    set_req(1, 1, 0, 4'hF, 32'h100, 32'h0);
    set_req(2, 1, 0, 4'hF, 32'h104, 32'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      order[i] = -1;
      ocyc[i]  = -1;
    end
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        if (core_ready[c] && n < 8) begin
          order[n] = c;
          ocyc[n]  = cyc;
          n++;
        end
      end
      if (core_ready[2]) begin
        check_eq("fair_core2_data", core_rdata[2*XLEN +: 32], pre[1]);
        drop(2);
      end
      if (core_ready[1] && n >= 3) drop(1);
    end
    check_eq("fair_grants", 32'(n), 32'd3);
    check_eq("fair_order0", 32'(order[0]), 32'd1);
    check_eq("fair_order1", 32'(order[1]), 32'd2);
    check_eq("fair_order2", 32'(order[2]), 32'd1);
    check_eq("fair_cycle1", 32'(ocyc[1]), 32'd4);
    check_eq("fair_cycle2", 32'(ocyc[2]), 32'd6);

    // Reset during the ACCESS cycle of a write
    serve(0, 0, 1, 4'hF, 32'h10, 32'h77, rd, lat);
    set_req(3, 0, 1, 4'hF, 32'h10, 32'h5);
    @(posedge clk); #1;
    rst = 1'b1;
    drop(3);
    @(posedge clk); #1;
    check_eq("midrst_ready_a", 32'(core_ready), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ready_b", 32'(core_ready), 32'h0);
    serve(0, 1, 0, 4'hF, 32'h10, 32'h0, rd, lat);
    check_eq("midrst_old_value", rd, 32'h77);

    // Address wrap and ignored low bits
    serve(0, 0, 1, 4'hF, 32'h0, 32'hCAFE, rd, lat);
    serve(2, 1, 0, 4'hF, 32'(DEPTH * 4), 32'h0, rd, lat);
    check_eq("wrap_depth", rd, 32'hCAFE);
    serve(3, 1, 0, 4'hF, 32'h3, 32'h0, rd, lat);
    check_eq("wrap_low_bits", rd, 32'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
